// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: PID codes, CRC5 constants, token decoder states.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_SOF   = 4'h5,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_t;

  localparam logic [4:0] CRC5_POLY    = 5'h05;
  localparam logic [4:0] CRC5_INIT    = 5'h1F;
  localparam logic [4:0] CRC5_RESIDUE = 5'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_WAIT_EOP,
    ST_DROP
  } rx_state_t;

  // True for the four PIDs that carry a token body (OUT, IN, SOF, SETUP).
  function automatic logic is_token_pid(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_crc5_serial.sv
// Serial CRC5 LFSR (x^5+x^2+1). crc_next exposes the value one shift ahead so
// the decoder can judge a packet whose last bit and EOP share a cycle.
module usb_crc5_serial #(
  parameter logic [4:0] INIT = usb_pkg::CRC5_INIT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       data_in,
  output logic [4:0] crc,
  output logic [4:0] crc_next
);
  import usb_pkg::*;

  logic fb;

  assign fb       = crc[4] ^ data_in;
  assign crc_next = {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);

  // CRC register: clear has priority over shifting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        crc <= INIT;
    else if (clear)    crc <= INIT;
    else if (shift_en) crc <= crc_next;
  end

endmodule

// File: rtl/usb_token_rx.sv
// USB token packet decoder: PID check, 16-bit body capture, CRC5 residue check,
// registered single-cycle status strobes one cycle after the deciding sample.
module usb_token_rx #(
  parameter logic [4:0] CRC5_INIT    = usb_pkg::CRC5_INIT,
  parameter logic [4:0] CRC5_RESIDUE = usb_pkg::CRC5_RESIDUE
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_sop,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  input  logic        rx_eop,
  input  logic        rx_abort,
  output logic [3:0]  token_pid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_num,
  output logic        token_valid,
  output logic        crc_err,
  output logic        pid_err,
  output logic        len_err
);
  import usb_pkg::*;

  rx_state_t   state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [7:0]  pid_byte, pid_byte_n;
  logic [15:0] body, body_n;
  logic [4:0]  crc, crc_next;
  logic        crc_clear, crc_shift, load_fields;
  logic        token_valid_n, crc_err_n, pid_err_n, len_err_n;

  usb_crc5_serial #(.INIT(CRC5_INIT)) u_crc (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .data_in  (rx_bit),
    .crc      (crc),
    .crc_next (crc_next)
  );

  // Next-state, datapath and strobe decode; a same-cycle bit is consumed before EOP is judged.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pid_byte_n    = pid_byte;
    body_n        = body;
    crc_clear     = 1'b0;
    crc_shift     = 1'b0;
    load_fields   = 1'b0;
    token_valid_n = 1'b0;
    crc_err_n     = 1'b0;
    pid_err_n     = 1'b0;
    len_err_n     = 1'b0;
    if (rx_sop) begin
      state_n   = ST_PID;
      cnt_n     = '0;
      crc_clear = 1'b1;
    end else if (rx_abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_PID: begin
          if (rx_bit_valid) begin
            pid_byte_n = {rx_bit, pid_byte[7:1]};
            cnt_n      = cnt + 5'd1;
          end
          if (rx_bit_valid && cnt == 5'd7) begin
            cnt_n = '0;
            if (pid_byte_n[7:4] != ~pid_byte_n[3:0]) begin
              pid_err_n = 1'b1;
              state_n   = rx_eop ? ST_IDLE : ST_DROP;
            end else if (!is_token_pid(pid_byte_n[3:0])) begin
              state_n = rx_eop ? ST_IDLE : ST_DROP;
            end else if (rx_eop) begin
              len_err_n = 1'b1;
              state_n   = ST_IDLE;
            end else begin
              state_n   = ST_BODY;
              crc_clear = 1'b1;
            end
          end else if (rx_eop) begin
            len_err_n = 1'b1;
            state_n   = ST_IDLE;
          end
        end
        ST_BODY: begin
          if (rx_bit_valid) begin
            body_n[cnt[3:0]] = rx_bit;
            crc_shift        = 1'b1;
            cnt_n            = cnt + 5'd1;
          end
          if (cnt_n == 5'd16) begin
            if (rx_eop) begin
              state_n = ST_IDLE;
              if (crc_next == CRC5_RESIDUE) begin
                token_valid_n = 1'b1;
                load_fields   = 1'b1;
              end else begin
                crc_err_n = 1'b1;
              end
            end else begin
              state_n = ST_WAIT_EOP;
            end
          end else if (rx_eop) begin
            len_err_n = 1'b1;
            state_n   = ST_IDLE;
          end
        end
        ST_WAIT_EOP: begin
          if (rx_bit_valid) begin
            len_err_n = 1'b1;
            state_n   = rx_eop ? ST_IDLE : ST_DROP;
          end else if (rx_eop) begin
            state_n = ST_IDLE;
            if (crc == CRC5_RESIDUE) begin
              token_valid_n = 1'b1;
              load_fields   = 1'b1;
            end else begin
              crc_err_n = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (rx_eop) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, datapath and output registers; fields change only with token_valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pid_byte    <= '0;
      body        <= '0;
      token_valid <= 1'b0;
      crc_err     <= 1'b0;
      pid_err     <= 1'b0;
      len_err     <= 1'b0;
      token_pid   <= '0;
      token_addr  <= '0;
      token_endp  <= '0;
      frame_num   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pid_byte    <= pid_byte_n;
      body        <= body_n;
      token_valid <= token_valid_n;
      crc_err     <= crc_err_n;
      pid_err     <= pid_err_n;
      len_err     <= len_err_n;
      if (load_fields) begin
        token_pid  <= pid_byte[3:0];
        token_addr <= body_n[6:0];
        token_endp <= body_n[10:7];
        frame_num  <= body_n[10:0];
      end
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Bench for usb_token_rx: directed token scenarios plus randomized packets,
// expected strobes/fields derived from packet-level rules.
module tb_usb_token_rx;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rx_sop, rx_bit, rx_bit_valid, rx_eop, rx_abort;
  logic [3:0]  token_pid;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic [10:0] frame_num;
  logic        token_valid, crc_err, pid_err, len_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [3:0]  exp_pid   = '0;
  logic [6:0]  exp_addr  = '0;
  logic [3:0]  exp_endp  = '0;
  logic [10:0] exp_frame = '0;

  // Strobe codes in the order {token_valid, crc_err, pid_err, len_err}.
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_TV   = 4'b1000;
  localparam logic [3:0] S_CRC  = 4'b0100;
  localparam logic [3:0] S_PID  = 4'b0010;
  localparam logic [3:0] S_LEN  = 4'b0001;

  usb_token_rx dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_sop       (rx_sop),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .rx_eop       (rx_eop),
    .rx_abort     (rx_abort),
    .token_pid    (token_pid),
    .token_addr   (token_addr),
    .token_endp   (token_endp),
    .frame_num    (frame_num),
    .token_valid  (token_valid),
    .crc_err      (crc_err),
    .pid_err      (pid_err),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  // Register value after shifting 16 body bits, from the x^5+x^2+1 rule.
  function automatic logic [4:0] crc_over(input logic [15:0] bits);
    logic [4:0] c;
    c = 5'h1F;
    for (int unsigned i = 0; i < 16; i++) begin
      if (c[4] ^ bits[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  // The one CRC field value that makes the 16-bit body hit the residue.
  function automatic logic [4:0] make_crc(input logic [6:0] a, input logic [3:0] e);
    for (int unsigned c = 0; c < 32; c++)
      if (crc_over({c[4:0], e, a}) == 5'h0C) return c[4:0];
    return 5'h00;
  endfunction

  function automatic logic [31:0] make_body(input logic [6:0] a, input logic [3:0] e, input bit good);
    logic [4:0] c;
    c = make_crc(a, e) ^ (good ? 5'h00 : 5'h01);
    return {$urandom_range(65535, 0) & 32'hFFFF, 16'h0} | {16'h0, c, e, a};
  endfunction

  task automatic step(input logic sop, input logic v, input logic b, input logic eop,
                      input logic abort, input logic [3:0] exp, input string tag);
    rx_sop = sop; rx_bit_valid = v; rx_bit = b; rx_eop = eop; rx_abort = abort;
    @(posedge clk); #1;
    rx_sop = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0; rx_eop = 1'b0; rx_abort = 1'b0;
    total++;
    assert ({token_valid, crc_err, pid_err, len_err} === exp) else begin
      bad++;
      $error("FAIL %s strobes(tv,crc,pid,len)=%b expected=%b", tag,
             {token_valid, crc_err, pid_err, len_err}, exp);
    end
  endtask

  task automatic check_fields(input string tag);
    total++;
    assert ({token_pid, token_addr, token_endp, frame_num} === {exp_pid, exp_addr, exp_endp, exp_frame}) else begin
      bad++;
      $error("FAIL %s fields pid/addr/endp/frame=%h/%h/%h/%h expected=%h/%h/%h/%h", tag,
             token_pid, token_addr, token_endp, frame_num, exp_pid, exp_addr, exp_endp, exp_frame);
    end
  endtask

  task automatic gaps(input int unsigned gap_max, input string tag);
    int unsigned n;
    n = $urandom_range(gap_max, 0);
    for (int unsigned k = 0; k < n; k++)
      step(1'b0, 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, S_NONE, {tag, "/gap"});
  endtask

  // Full packet: SOP, PID byte, nbody body bits, EOP (optionally with the last bit).
  task automatic send_pkt(input logic [7:0] pid, input logic [31:0] body, input int unsigned nbody,
                          input bit eop_same, input bit abort_too, input int unsigned gap_max,
                          input string tag);
    bit         pid_ok, tok;
    logic [3:0] ex, eop_ex;
    pid_ok = (pid[7:4] == ~pid[3:0]);
    tok    = pid_ok && (pid[3:0] == 4'h1 || pid[3:0] == 4'h9 || pid[3:0] == 4'h5 || pid[3:0] == 4'hD);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'(abort_too), S_NONE, {tag, "/sop"});
    for (int unsigned i = 0; i < 8; i++) begin
      gaps(gap_max, tag);
      step(1'b0, 1'b1, pid[i], 1'b0, 1'b0, (i == 7 && !pid_ok) ? S_PID : S_NONE, {tag, "/pid"});
    end
    if (!tok)                                 eop_ex = S_NONE;
    else if (nbody > 16)                      eop_ex = S_NONE;
    else if (nbody < 16)                      eop_ex = S_LEN;
    else if (crc_over(body[15:0]) == 5'h0C)   eop_ex = S_TV;
    else                                      eop_ex = S_CRC;
    for (int unsigned i = 0; i < nbody; i++) begin
      gaps(gap_max, tag);
      ex = (tok && i == 16) ? S_LEN : S_NONE;
      if (eop_same && i == nbody - 1)
        step(1'b0, 1'b1, body[i], 1'b1, 1'b0, ex | eop_ex, {tag, "/bit+eop"});
      else
        step(1'b0, 1'b1, body[i], 1'b0, 1'b0, ex, {tag, "/body"});
    end
    if (!eop_same || nbody == 0) begin
      gaps(gap_max, tag);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, eop_ex, {tag, "/eop"});
    end
    if (eop_ex == S_TV) begin
      exp_pid   = pid[3:0];
      exp_addr  = body[6:0];
      exp_endp  = body[10:7];
      exp_frame = body[10:0];
    end
    check_fields(tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, {tag, "/after"});
  endtask

  // SOP, a good token PID and k body bits, left in flight.
  task automatic send_partial(input logic [7:0] pid, input logic [31:0] body, input int unsigned k,
                              input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, {tag, "/sop"});
    for (int unsigned i = 0; i < 8; i++)
      step(1'b0, 1'b1, pid[i], 1'b0, 1'b0, S_NONE, {tag, "/pid"});
    for (int unsigned i = 0; i < k; i++)
      step(1'b0, 1'b1, body[i], 1'b0, 1'b0, S_NONE, {tag, "/body"});
  endtask

  initial begin
    logic [31:0] b;
    logic [7:0]  p;
    logic [7:0]  tok_pids [4];
    logic [7:0]  other_pids [3];
    int unsigned nb;
    tok_pids   = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
    other_pids = '{8'hC3, 8'hD2, 8'h5A};

    n_rst = 1'b0; rx_sop = 1'b0; rx_bit = 1'b0; rx_bit_valid = 1'b0; rx_eop = 1'b0; rx_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    assert ({token_valid, crc_err, pid_err, len_err} === 4'b0000) else begin
      bad++; $error("FAIL reset strobes=%b expected=0000", {token_valid, crc_err, pid_err, len_err});
    end
    check_fields("reset");
    n_rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, S_NONE, "idle_ignores");

    // OUT addr 15 endp E with good CRC, then a corrupted CRC.
    b = make_body(7'h15, 4'hE, 1'b1);
    send_pkt(8'hE1, b, 16, 1'b0, 1'b0, 0, "out_good");
    b = make_body(7'h15, 4'hE, 1'b0);
    send_pkt(8'hE1, b, 16, 1'b0, 1'b0, 0, "out_badcrc");
    b = make_body(7'h3A, 4'hA, 1'b1);
    send_pkt(8'h69, b, 16, 1'b0, 1'b0, 0, "in_good");
    // Bad PID check nibble: error after the 8th bit, nothing at EOP.
    send_pkt(8'hE0, b, 16, 1'b0, 1'b0, 0, "pid_bad");
    // Short and long bodies.
    b = make_body(7'h15, 4'hE, 1'b1);
    send_pkt(8'hE1, b, 10, 1'b0, 1'b0, 0, "short10");
    send_pkt(8'hE1, b, 17, 1'b0, 1'b0, 0, "long17");
    send_pkt(8'hE1, b, 0, 1'b0, 1'b0, 0, "empty_body");
    // Last bit and EOP in the same cycle.
    b = make_body(7'h7F, 4'h0, 1'b1);
    send_pkt(8'h2D, b, 16, 1'b1, 1'b0, 0, "setup_eop_same");
    b = make_body(7'h55, 4'hB, 1'b1);
    send_pkt(8'hA5, b, 16, 1'b0, 1'b0, 1, "sof_frame");
    // Non-token PID with a valid check nibble: silent.
    send_pkt(8'hC3, b, 16, 1'b0, 1'b0, 0, "data0_silent");

    // Abort at body bit 6, EOP in idle, then a good IN token.
    b = make_body(7'h01, 4'h2, 1'b1);
    send_partial(8'hE1, b, 6, "abort_part");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, "abort");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, "abort_eop");
    b = make_body(7'h3A, 4'hA, 1'b1);
    send_pkt(8'h69, b, 16, 1'b0, 1'b0, 0, "after_abort");

    // SOP restarts an in-flight packet, and wins over a simultaneous abort.
    send_partial(8'hE1, b, 12, "restart_part");
    b = make_body(7'h22, 4'h3, 1'b1);
    send_pkt(8'hE1, b, 16, 1'b0, 1'b1, 0, "restart_sop_abort");

    // Reset asserted mid-body clears everything with no strobe.
    send_partial(8'h69, b, 5, "rst_part");
    #2 n_rst = 1'b0;
    #1;
    exp_pid = '0; exp_addr = '0; exp_endp = '0; exp_frame = '0;
    total++;
    assert ({token_valid, crc_err, pid_err, len_err} === 4'b0000) else begin
      bad++; $error("FAIL midrst strobes=%b expected=0000", {token_valid, crc_err, pid_err, len_err});
    end
    check_fields("midrst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_NONE, "rst_bit");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, "rst_eop");

    // Randomized packets.
    for (int unsigned n = 0; n < 40; n++) begin
      case ($urandom_range(9, 0))
        0: begin
          p = 8'($urandom_range(255, 0));
          if (p[7:4] == ~p[3:0]) p[4] = ~p[4];
        end
        1:       p = other_pids[$urandom_range(2, 0)];
        default: p = tok_pids[$urandom_range(3, 0)];
      endcase
      b = make_body(7'($urandom_range(127, 0)), 4'($urandom_range(15, 0)), $urandom_range(3, 0) != 0);
      nb = ($urandom_range(4, 0) == 0) ? $urandom_range(18, 8) : 16;
      send_pkt(p, b, nb, 1'($urandom_range(1, 0)), 1'b0, 2, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
